// File: rtl/mem_stage_if.sv
// Handshake bundles around the memory stage: execute -> stage issue port,
// and stage -> data-memory request port.
interface exe_mem_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] exe_out;
   logic [31:0] store_data;
   logic        is_load;
   logic        is_store;
   logic        needs_wb;
   logic [3:0]  wb_addr;
   logic [31:0] pc_in;
   logic        z_flag;

   modport master (
      output in_valid, exe_out, store_data, is_load, is_store,
             needs_wb, wb_addr, pc_in, z_flag,
      input  in_ready
   );
   modport slave (
      input  in_valid, exe_out, store_data, is_load, is_store,
             needs_wb, wb_addr, pc_in, z_flag,
      output in_ready
   );
endinterface

interface dmem_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_ack, dmem_rdata
   );
   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: latches one instruction, runs a load/store over req/ack
// with a timeout, and emits a single-cycle write-back packet.
//
// state  | meaning
// IDLE   | ready for a new instruction; ALU ops and misaligned ops retire from here
// ACCESS | memory request outstanding, waiting for ack or timeout
module mem_stage #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   exe_mem_if.slave    exe,
   dmem_if.master      dmem,
   output logic        wb_valid,
   output logic        wb_en,
   output logic [3:0]  wb_addr_out,
   output logic [31:0] wb_data,
   output logic [31:0] pc_out,
   output logic        z_flag_out,
   output logic        mem_err
);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t      state_q, state_d;
   logic [7:0]  tmr_q, tmr_d;
   logic [31:0] exe_q, exe_d;
   logic [31:0] sdata_q, sdata_d;
   logic        we_q, we_d;
   logic        needs_wb_q, needs_wb_d;
   logic [3:0]  waddr_q, waddr_d;
   logic [31:0] pc_q, pc_d;
   logic        z_q, z_d;

   logic        wb_valid_q, wb_valid_d;
   logic        wb_en_q, wb_en_d;
   logic        mem_err_q, mem_err_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic [3:0]  wb_addr_q, wb_addr_d;
   logic [31:0] wb_pc_q, wb_pc_d;
   logic        wb_z_q, wb_z_d;

   logic        is_mem;
   logic        misaligned;

   assign is_mem     = exe.is_load | exe.is_store;
   assign misaligned = exe.exe_out[1:0] != 2'b00;

   always_comb begin
      state_d    = state_q;
      tmr_d      = tmr_q;
      exe_d      = exe_q;
      sdata_d    = sdata_q;
      we_d       = we_q;
      needs_wb_d = needs_wb_q;
      waddr_d    = waddr_q;
      pc_d       = pc_q;
      z_d        = z_q;
      wb_valid_d = 1'b0;
      wb_en_d    = 1'b0;
      mem_err_d  = 1'b0;
      wb_data_d  = wb_data_q;
      wb_addr_d  = wb_addr_q;
      wb_pc_d    = wb_pc_q;
      wb_z_d     = wb_z_q;

      case (state_q)
         IDLE: begin
            if (exe.in_valid) begin
               exe_d      = exe.exe_out;
               sdata_d    = exe.store_data;
               we_d       = exe.is_store;
               needs_wb_d = exe.needs_wb;
               waddr_d    = exe.wb_addr;
               pc_d       = exe.pc_in;
               z_d        = exe.z_flag;
               if (is_mem && !misaligned) begin
                  state_d = ACCESS;
                  tmr_d   = 8'(MEM_TIMEOUT);
               end else begin
                  // retires straight from the inputs so back-to-back issue works
                  wb_valid_d = 1'b1;
                  wb_en_d    = exe.needs_wb & ~is_mem;
                  mem_err_d  = is_mem;
                  wb_data_d  = exe.exe_out;
                  wb_addr_d  = exe.wb_addr;
                  wb_pc_d    = exe.pc_in;
                  wb_z_d     = exe.z_flag;
               end
            end
         end
         ACCESS: begin
            // down-counter: reaching 1 means MEM_TIMEOUT access cycles have elapsed
            if (dmem.dmem_ack || tmr_q == 8'd1) begin
               state_d    = IDLE;
               tmr_d      = 8'd0;
               wb_valid_d = 1'b1;
               wb_en_d    = dmem.dmem_ack & ~we_q & needs_wb_q;
               mem_err_d  = ~dmem.dmem_ack;
               wb_data_d  = (dmem.dmem_ack && !we_q) ? dmem.dmem_rdata : exe_q;
               wb_addr_d  = waddr_q;
               wb_pc_d    = pc_q;
               wb_z_d     = z_q;
            end else begin
               tmr_d = tmr_q - 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         tmr_q      <= 8'd0;
         exe_q      <= 32'd0;
         sdata_q    <= 32'd0;
         we_q       <= 1'b0;
         needs_wb_q <= 1'b0;
         waddr_q    <= 4'd0;
         pc_q       <= 32'd0;
         z_q        <= 1'b0;
         wb_valid_q <= 1'b0;
         wb_en_q    <= 1'b0;
         mem_err_q  <= 1'b0;
         wb_data_q  <= 32'd0;
         wb_addr_q  <= 4'd0;
         wb_pc_q    <= 32'd0;
         wb_z_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         exe_q      <= exe_d;
         sdata_q    <= sdata_d;
         we_q       <= we_d;
         needs_wb_q <= needs_wb_d;
         waddr_q    <= waddr_d;
         pc_q       <= pc_d;
         z_q        <= z_d;
         wb_valid_q <= wb_valid_d;
         wb_en_q    <= wb_en_d;
         mem_err_q  <= mem_err_d;
         wb_data_q  <= wb_data_d;
         wb_addr_q  <= wb_addr_d;
         wb_pc_q    <= wb_pc_d;
         wb_z_q     <= wb_z_d;
      end
   end

   assign exe.in_ready     = (state_q == IDLE);
   assign dmem.dmem_req    = (state_q == ACCESS);
   assign dmem.dmem_we     = (state_q == ACCESS) & we_q;
   assign dmem.dmem_addr   = {exe_q[31:2], 2'b00};
   assign dmem.dmem_wdata  = sdata_q;

   assign wb_valid    = wb_valid_q;
   assign wb_en       = wb_en_q;
   assign mem_err     = mem_err_q;
   assign wb_data     = wb_data_q;
   assign wb_addr_out = wb_addr_q;
   assign pc_out      = wb_pc_q;
   assign z_flag_out  = wb_z_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (MEM_TIMEOUT=4): vector table plus hand-written
// sequences for reset, back-to-back issue and spurious ack.
module tb_mem_stage;

   logic        clk;
   logic        rst_n;
   logic        wb_valid, wb_en, z_flag_out, mem_err;
   logic [3:0]  wb_addr_out;
   logic [31:0] wb_data, pc_out;

   exe_mem_if exe ();
   dmem_if    dmem ();

   mem_stage #(.MEM_TIMEOUT(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .exe         (exe),
      .dmem        (dmem),
      .wb_valid    (wb_valid),
      .wb_en       (wb_en),
      .wb_addr_out (wb_addr_out),
      .wb_data     (wb_data),
      .pc_out      (pc_out),
      .z_flag_out  (z_flag_out),
      .mem_err     (mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] exe_out;
      logic [31:0] store_data;
      logic        is_load;
      logic        is_store;
      logic        needs_wb;
      logic [3:0]  wb_addr;
      logic [31:0] pc;
      logic        z;
      int          ack_k;      // edge after accept at which ack is sampled; 0 = never
      logic [31:0] rdata;
      int          exp_lat;
      int          exp_req;
      logic        exp_we;
      logic        exp_wb_en;
      logic        exp_err;
      logic        chk_data;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[10];
   int   n_vec;
   int   n_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      exe.in_valid   = 1'b0;
      exe.exe_out    = 32'd0;
      exe.store_data = 32'd0;
      exe.is_load    = 1'b0;
      exe.is_store   = 1'b0;
      exe.needs_wb   = 1'b0;
      exe.wb_addr    = 4'd0;
      exe.pc_in      = 32'd0;
      exe.z_flag     = 1'b0;
      dmem.dmem_ack  = 1'b0;
      dmem.dmem_rdata = 32'd0;
   endtask

   task automatic drive_alu(input logic [31:0] val, input logic [3:0] wa, input logic [31:0] pc);
      exe.in_valid = 1'b1;
      exe.exe_out  = val;
      exe.is_load  = 1'b0;
      exe.is_store = 1'b0;
      exe.needs_wb = 1'b1;
      exe.wb_addr  = wa;
      exe.pc_in    = pc;
      exe.z_flag   = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      bit got;
      int reqs;
      got  = 0;
      reqs = 0;
      @(negedge clk);
      exe.in_valid   = 1'b1;
      exe.exe_out    = v.exe_out;
      exe.store_data = v.store_data;
      exe.is_load    = v.is_load;
      exe.is_store   = v.is_store;
      exe.needs_wb   = v.needs_wb;
      exe.wb_addr    = v.wb_addr;
      exe.pc_in      = v.pc;
      exe.z_flag     = v.z;
      dmem.dmem_rdata = v.rdata;
      chk($sformatf("v%0d in_ready_before", idx), {31'd0, exe.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      exe.in_valid = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         dmem.dmem_ack = (n == v.ack_k);
         if (dmem.dmem_req) begin
            reqs++;
            chk($sformatf("v%0d dmem_addr", idx), dmem.dmem_addr, v.exe_out & 32'hFFFF_FFFC);
            chk($sformatf("v%0d dmem_we", idx), {31'd0, dmem.dmem_we}, {31'd0, v.exp_we});
            if (v.exp_we)
               chk($sformatf("v%0d dmem_wdata", idx), dmem.dmem_wdata, v.store_data);
            chk($sformatf("v%0d in_ready_busy", idx), {31'd0, exe.in_ready}, 32'd0);
         end
         if (wb_valid) begin
            got = 1;
            chk($sformatf("v%0d latency", idx), n, v.exp_lat);
            chk($sformatf("v%0d wb_en", idx), {31'd0, wb_en}, {31'd0, v.exp_wb_en});
            chk($sformatf("v%0d mem_err", idx), {31'd0, mem_err}, {31'd0, v.exp_err});
            chk($sformatf("v%0d wb_addr_out", idx), {28'd0, wb_addr_out}, {28'd0, v.wb_addr});
            chk($sformatf("v%0d pc_out", idx), pc_out, v.pc);
            chk($sformatf("v%0d z_flag_out", idx), {31'd0, z_flag_out}, {31'd0, v.z});
            chk($sformatf("v%0d in_ready_wb", idx), {31'd0, exe.in_ready}, 32'd1);
            if (v.chk_data)
               chk($sformatf("v%0d wb_data", idx), wb_data, v.exp_data);
            break;
         end
         @(posedge clk);
         #1;
      end
      dmem.dmem_ack = 1'b0;
      if (!got) begin
         n_err++;
         $display("FAIL v%0d wb_valid_timeout: got none within 20 cycles expected latency %0d", idx, v.exp_lat);
      end
      chk($sformatf("v%0d req_cycles", idx), reqs, v.exp_req);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d wb_valid_pulse", idx), {31'd0, wb_valid}, 32'd0);
      chk($sformatf("v%0d mem_err_pulse", idx), {31'd0, mem_err}, 32'd0);
      chk($sformatf("v%0d req_after", idx), {31'd0, dmem.dmem_req}, 32'd0);
      n_vec++;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      //          exe_out       sdata         ld   st   nwb  wa    pc            z    k  rdata         lat req we   en   err  cd   data
      vecs[0] = '{32'h1234_5678, 32'h0,        1'b0,1'b0,1'b1,4'd5, 32'h0000_0100,1'b1,0, 32'h0,        1, 0, 1'b0,1'b1,1'b0,1'b1,32'h1234_5678};
      vecs[1] = '{32'h0000_00AA, 32'h0,        1'b0,1'b0,1'b0,4'd6, 32'h0000_0104,1'b0,0, 32'h0,        1, 0, 1'b0,1'b0,1'b0,1'b1,32'h0000_00AA};
      vecs[2] = '{32'h0000_0100, 32'h0,        1'b1,1'b0,1'b1,4'd7, 32'h0000_0108,1'b1,3, 32'hDEAD_BEEF,4, 3, 1'b0,1'b1,1'b0,1'b1,32'hDEAD_BEEF};
      vecs[3] = '{32'h0000_0204, 32'hCAFE_0001,1'b0,1'b1,1'b1,4'd8, 32'h0000_010C,1'b0,1, 32'h1111_1111,2, 1, 1'b1,1'b0,1'b0,1'b1,32'h0000_0204};
      vecs[4] = '{32'h0000_0102, 32'h0,        1'b1,1'b0,1'b1,4'd9, 32'h0000_0110,1'b0,1, 32'h0,        1, 0, 1'b0,1'b0,1'b1,1'b0,32'h0};
      vecs[5] = '{32'h0000_0300, 32'h0,        1'b1,1'b0,1'b1,4'd10,32'h0000_0114,1'b1,0, 32'h0,        5, 4, 1'b0,1'b0,1'b1,1'b0,32'h0};
      vecs[6] = '{32'h0000_0400, 32'h0,        1'b1,1'b0,1'b1,4'd11,32'h0000_0118,1'b0,4, 32'h0000_55AA,5, 4, 1'b0,1'b1,1'b0,1'b1,32'h0000_55AA};
      vecs[7] = '{32'h0000_0008, 32'h0000_0077,1'b1,1'b1,1'b1,4'd12,32'h0000_011C,1'b1,2, 32'h9999_9999,3, 2, 1'b1,1'b0,1'b0,1'b1,32'h0000_0008};
      vecs[8] = '{32'h0000_0203, 32'h0000_0055,1'b0,1'b1,1'b0,4'd13,32'h0000_0120,1'b0,0, 32'h0,        1, 0, 1'b0,1'b0,1'b1,1'b0,32'h0};
      vecs[9] = '{32'h0000_0500, 32'h0,        1'b1,1'b0,1'b0,4'd14,32'h0000_0124,1'b0,2, 32'h0BAD_F00D,3, 2, 1'b0,1'b0,1'b0,1'b1,32'h0BAD_F00D};

      idle_inputs();
      rst_n = 1'b0;
      #3;
      chk("rst in_ready", {31'd0, exe.in_ready}, 32'd1);
      chk("rst dmem_req", {31'd0, dmem.dmem_req}, 32'd0);
      chk("rst dmem_we", {31'd0, dmem.dmem_we}, 32'd0);
      chk("rst dmem_addr", dmem.dmem_addr, 32'd0);
      chk("rst wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst wb_en", {31'd0, wb_en}, 32'd0);
      chk("rst mem_err", {31'd0, mem_err}, 32'd0);
      chk("rst wb_data", wb_data, 32'd0);
      chk("rst pc_out", pc_out, 32'd0);
      chk("rst z_flag_out", {31'd0, z_flag_out}, 32'd0);
      n_vec++;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

      // three back-to-back ALU ops retire on consecutive cycles
      @(negedge clk);
      drive_alu(32'h10, 4'd1, 32'h200);
      @(posedge clk); #1;
      chk("b2b in_ready0", {31'd0, exe.in_ready}, 32'd1);
      drive_alu(32'h20, 4'd2, 32'h204);
      chk("b2b valid1", {31'd0, wb_valid}, 32'd1);
      chk("b2b data1", wb_data, 32'h10);
      chk("b2b addr1", {28'd0, wb_addr_out}, 32'd1);
      @(posedge clk); #1;
      chk("b2b in_ready1", {31'd0, exe.in_ready}, 32'd1);
      drive_alu(32'h30, 4'd3, 32'h208);
      chk("b2b valid2", {31'd0, wb_valid}, 32'd1);
      chk("b2b data2", wb_data, 32'h20);
      chk("b2b addr2", {28'd0, wb_addr_out}, 32'd2);
      @(posedge clk); #1;
      chk("b2b in_ready2", {31'd0, exe.in_ready}, 32'd1);
      exe.in_valid = 1'b0;
      chk("b2b valid3", {31'd0, wb_valid}, 32'd1);
      chk("b2b data3", wb_data, 32'h30);
      chk("b2b addr3", {28'd0, wb_addr_out}, 32'd3);
      chk("b2b pc3", pc_out, 32'h208);
      @(posedge clk); #1;
      chk("b2b valid_end", {31'd0, wb_valid}, 32'd0);
      chk("b2b data_hold", wb_data, 32'h30);
      n_vec++;

      // spurious ack while idle must not produce a packet or a request
      dmem.dmem_ack = 1'b1;
      dmem.dmem_rdata = 32'hFFFF_0000;
      for (int n = 0; n < 3; n++) begin
         @(posedge clk); #1;
         chk("spurious wb_valid", {31'd0, wb_valid}, 32'd0);
         chk("spurious dmem_req", {31'd0, dmem.dmem_req}, 32'd0);
      end
      dmem.dmem_ack = 1'b0;
      n_vec++;

      // reset during ACCESS: request drops without a clock edge, nothing retires
      @(negedge clk);
      exe.in_valid = 1'b1;
      exe.exe_out  = 32'h0000_0600;
      exe.is_load  = 1'b1;
      exe.is_store = 1'b0;
      exe.needs_wb = 1'b1;
      exe.wb_addr  = 4'd4;
      exe.pc_in    = 32'h300;
      exe.z_flag   = 1'b1;
      @(posedge clk); #1;
      exe.in_valid = 1'b0;
      exe.is_load  = 1'b0;
      @(posedge clk); #1;
      chk("rstacc req_before", {31'd0, dmem.dmem_req}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstacc req_drop", {31'd0, dmem.dmem_req}, 32'd0);
      chk("rstacc in_ready", {31'd0, exe.in_ready}, 32'd1);
      chk("rstacc wb_data", wb_data, 32'd0);
      chk("rstacc pc_out", pc_out, 32'd0);
      chk("rstacc dmem_addr", dmem.dmem_addr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 6; n++) begin
         @(posedge clk); #1;
         chk("rstacc no_wb", {31'd0, wb_valid}, 32'd0);
         chk("rstacc no_req", {31'd0, dmem.dmem_req}, 32'd0);
      end
      n_vec++;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
